// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_scanner
//  Description : Scans a 4x4 active-low matrix keypad one column at a time.
//                Rows pass through a 2-FF synchronizer. A full scan is
//                classified as no key, one key or several keys. Results are
//                debounced across whole scans. Each new keypress is presented
//                over a valid/ack handshake and shifted into an 8-bit
//                two-digit entry value.
//  Ports       : clk, rst    - clock, synchronous active-high reset
//                row_in[3:0] - keypad rows, active-low, asynchronous
//                col_out[3:0]- column drive, active-low one-hot
//                key_code    - code {row,col} of the accepted key
//                key_valid   - accepted key pending until key_ack
//                key_ack     - consumer acknowledge (ignored when idle)
//                overrun     - sticky, press arrived while key_valid was high
//                entry[7:0]  - {previous digit, newest digit}
//  Revision    : 1.0 - initial release
// ============================================================================
module keypad_scanner #(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ack,
    output logic       overrun,
    output logic [7:0] entry
);

    localparam int c_div_w = $clog2(SCAN_DIV);
    localparam int c_cnt_w = $clog2(DEBOUNCE_SCANS + 1);

    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(SCAN_DIV - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_max  = c_cnt_w'(DEBOUNCE_SCANS);

    // Scan result classes
    localparam logic [1:0] c_res_none  = 2'd0;
    localparam logic [1:0] c_res_key   = 2'd1;
    localparam logic [1:0] c_res_multi = 2'd2;

    // Press-tracking states
    localparam logic [0:0] c_st_idle    = 1'b0;
    localparam logic [0:0] c_st_pressed = 1'b1;

    // ------------------------------------------------------------------
    // Row synchronizer; resets to "all released" so no false press occurs
    // ------------------------------------------------------------------
    logic [3:0] r_row_meta;
    logic [3:0] r_row_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_row_meta <= 4'hF;
            r_row_sync <= 4'hF;
        end else begin
            r_row_meta <= row_in;
            r_row_sync <= r_row_meta;
        end
    end

    // ------------------------------------------------------------------
    // Column dwell divider and column index
    // ------------------------------------------------------------------
    logic [c_div_w-1:0] r_div;
    logic [1:0]         r_col;
    logic               w_sample;
    logic               w_scan_end;

    assign w_sample   = (r_div == c_div_last);
    assign w_scan_end = w_sample && (r_col == 2'd3);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div <= '0;
            r_col <= 2'd0;
        end else if (w_sample) begin
            r_div <= '0;
            r_col <= r_col + 2'd1;
        end else begin
            r_div <= r_div + c_div_w'(1);
        end
    end

    assign col_out = ~(4'b0001 << r_col);

    // ------------------------------------------------------------------
    // Key map: bit {row,col} holds the last sample of that intersection.
    // w_map_next merges the column being sampled now, so the column-3
    // sample can be classified on the same edge it is taken.
    // ------------------------------------------------------------------
    logic [15:0] r_map;
    logic [15:0] w_map_next;

    always_comb begin
        w_map_next = r_map;
        for (int r = 0; r < 4; r++) begin
            w_map_next[{2'(r), r_col}] = ~r_row_sync[r];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_map <= '0;
        end else if (w_sample) begin
            r_map <= w_map_next;
        end
    end

    // Classify the full scan: count saturates at 2, which already means MULTI
    logic [1:0] w_ones;
    logic [3:0] w_idx;
    logic [1:0] w_res_kind;
    logic [3:0] w_res_code;

    always_comb begin
        w_ones = 2'd0;
        w_idx  = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (w_map_next[i]) begin
                if (w_ones != 2'd2) begin
                    w_ones = w_ones + 2'd1;
                end
                w_idx = 4'(i);
            end
        end
        case (w_ones)
            2'd0:    w_res_kind = c_res_none;
            2'd1:    w_res_kind = c_res_key;
            default: w_res_kind = c_res_multi;
        endcase
        // Code is forced to zero for non-key results so candidates compare cleanly
        w_res_code = (w_ones == 2'd1) ? w_idx : 4'd0;
    end

    // ------------------------------------------------------------------
    // Debounce across whole scans
    // ------------------------------------------------------------------
    logic [1:0]         r_cand_kind;
    logic [3:0]         r_cand_code;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_scan_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cand_kind <= c_res_none;
            r_cand_code <= 4'd0;
            r_cnt       <= '0;
            r_scan_done <= 1'b0;
        end else begin
            r_scan_done <= w_scan_end;
            if (w_scan_end) begin
                if ((w_res_kind == r_cand_kind) && (w_res_code == r_cand_code)) begin
                    if (r_cnt != c_cnt_max) begin
                        r_cnt <= r_cnt + c_cnt_w'(1);
                    end
                end else begin
                    r_cand_kind <= w_res_kind;
                    r_cand_code <= w_res_code;
                    r_cnt       <= c_cnt_w'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Press FSM: evaluated one clk after the scan that updated the debouncer
    // ------------------------------------------------------------------
    logic [0:0] r_state;
    logic [0:0] w_state_next;
    logic       w_stable;
    logic       w_press_event;

    assign w_stable = r_scan_done && (r_cnt == c_cnt_max);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_press_event = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (w_stable && (r_cand_kind == c_res_key)) begin
                    w_state_next  = c_st_pressed;
                    w_press_event = 1'b1;
                end
            end
            c_st_pressed: begin
                // A different stable key or MULTI is ignored: no roll-over
                if (w_stable && (r_cand_kind == c_res_none)) begin
                    w_state_next = c_st_idle;
                end
            end
            default: w_state_next = c_st_idle;
        endcase
    end

    // ------------------------------------------------------------------
    // Output register and valid/ack handshake
    // ------------------------------------------------------------------
    logic [3:0] r_key_code;
    logic       r_key_valid;
    logic       r_overrun;
    logic [7:0] r_entry;
    logic       w_ack;

    assign w_ack = key_ack && r_key_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_key_code  <= 4'd0;
            r_key_valid <= 1'b0;
            r_overrun   <= 1'b0;
            r_entry     <= 8'h00;
        end else if (w_press_event && (!r_key_valid || w_ack)) begin
            // Slot is free (or being freed this cycle): accept the new key
            r_key_code  <= r_cand_code;
            r_key_valid <= 1'b1;
            r_overrun   <= 1'b0;
            r_entry     <= {r_entry[3:0], r_cand_code};
        end else if (w_press_event) begin
            r_overrun <= 1'b1;
        end else if (w_ack) begin
            r_key_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end
    end

    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;
    assign overrun   = r_overrun;
    assign entry     = r_entry;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_keypad_scanner
//  Description : Self-checking bench for keypad_scanner with SCAN_DIV=4,
//                DEBOUNCE_SCANS=3. A passive keypad model turns a set of
//                pressed keys into row levels for the driven column.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_scanner;

    localparam int SD  = 4;
    localparam int DEB = 3;

    localparam int K_NONE  = 0;
    localparam int K_KEY   = 1;
    localparam int K_MULTI = 2;

    logic       clk;
    logic       rst;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ack;
    logic       overrun;
    logic [7:0] entry;

    logic [15:0] pressed;   // bit index = key code = {row,col}

    int n_checks = 0;
    int n_fail   = 0;
    int rises    = 0;
    logic prev_valid = 1'b0;

    keypad_scanner #(
        .SCAN_DIV       (SD),
        .DEBOUNCE_SCANS (DEB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .row_in    (row_in),
        .col_out   (col_out),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_ack   (key_ack),
        .overrun   (overrun),
        .entry     (entry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Passive keypad: a row reads low when a pressed key joins it to a driven column
    always_comb begin
        row_in = 4'hF;
        for (int r = 0; r < 4; r++) begin
            row_in[r] = ~|(pressed[r*4 +: 4] & ~col_out);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model, stepped on every rising edge
    // ------------------------------------------------------------------
    int          m_n;
    logic [15:0] m_scan;
    logic [15:0] p_d1, p_d2;
    int          m_cand_kind;
    logic [3:0]  m_cand_code;
    int          m_cnt;
    bit          m_held;
    bit          m_eval;
    bit          m_valid;
    logic [3:0]  m_code;
    bit          m_over;
    logic [7:0]  m_entry;
    bit          m_init = 1'b0;

    task automatic model_step();
        bit         ev;
        bit         ack;
        int         c;
        int         ones;
        int         kind;
        logic [3:0] code;
        if (rst) begin
            m_n = 0; m_scan = '0; p_d1 = '0; p_d2 = '0;
            m_cand_kind = K_NONE; m_cand_code = 4'd0; m_cnt = 0;
            m_held = 0; m_eval = 0;
            m_valid = 0; m_code = 4'd0; m_over = 0; m_entry = 8'h00;
            m_init = 1'b1;
        end else if (m_init) begin
            ev = 0;
            if (m_eval && m_cnt == DEB) begin
                if (!m_held && m_cand_kind == K_KEY) begin
                    m_held = 1; ev = 1;
                end else if (m_held && m_cand_kind == K_NONE) begin
                    m_held = 0;
                end
            end
            m_eval = 0;
            ack = key_ack && m_valid;
            if (ev && (!m_valid || ack)) begin
                m_code = m_cand_code; m_valid = 1; m_over = 0;
                m_entry = {m_entry[3:0], m_cand_code};
            end else if (ev) begin
                m_over = 1;
            end else if (ack) begin
                m_valid = 0; m_over = 0;
            end
            // Rows seen at a column sample were captured two edges earlier
            if (m_n % SD == SD - 1) begin
                c = (m_n / SD) % 4;
                for (int r = 0; r < 4; r++) m_scan[r*4 + c] = p_d2[r*4 + c];
                if (c == 3) begin
                    ones = $countones(m_scan);
                    code = 4'd0;
                    if (ones == 1) begin
                        for (int i = 0; i < 16; i++) if (m_scan[i]) code = 4'(i);
                    end
                    kind = (ones == 0) ? K_NONE : (ones == 1) ? K_KEY : K_MULTI;
                    if (kind == m_cand_kind && code == m_cand_code) begin
                        if (m_cnt < DEB) m_cnt++;
                    end else begin
                        m_cand_kind = kind; m_cand_code = code; m_cnt = 1;
                    end
                    m_eval = 1;
                end
            end
            p_d2 = p_d1;
            p_d1 = pressed;
            m_n++;
        end
    endtask

    always @(posedge clk) model_step();

    // Compare every cycle, away from the active edge
    always @(negedge clk) begin
        if (m_init) begin
            chk("col_out",   {28'd0, col_out},   {28'd0, ~(4'b0001 << ((m_n / SD) % 4))});
            chk("key_valid", {31'd0, key_valid}, {31'd0, m_valid});
            chk("key_code",  {28'd0, key_code},  {28'd0, m_code});
            chk("overrun",   {31'd0, overrun},   {31'd0, m_over});
            chk("entry",     {24'd0, entry},     {24'd0, m_entry});
        end
        if (key_valid === 1'b1 && prev_valid === 1'b0) rises++;
        prev_valid = key_valid;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int budget);
        int i;
        i = 0;
        while (i < budget && key_valid !== 1'b1) begin
            tick(1);
            i++;
        end
        chk("wait_valid", {31'd0, key_valid}, 32'd1);
    endtask

    task automatic ack_once();
        key_ack = 1'b1;
        tick(1);
        key_ack = 1'b0;
    endtask

    logic [3:0] walk [4];

    initial begin
        walk[0] = 4'b1110; walk[1] = 4'b1101; walk[2] = 4'b1011; walk[3] = 4'b0111;
        rst = 1'b1; key_ack = 1'b0; pressed = '0;
        tick(3);
        rst = 1'b0;

        // 1. Idle scanning
        chk("reset_entry", {24'd0, entry}, 32'h00);
        chk("reset_valid", {31'd0, key_valid}, 32'd0);
        for (int i = 0; i < 16; i++) begin
            chk("col_walk", {28'd0, col_out}, {28'd0, walk[(i / 4) % 4]});
            tick(1);
        end
        tick(484);
        chk("idle_rises", rises, 0);
        chk("idle_entry", {24'd0, entry}, 32'h00);

        // 2. Key 0x9, ack, held without a second event
        rises = 0;
        pressed = 16'h1 << 9;
        wait_valid(80);
        chk("k9_code",  {28'd0, key_code}, 32'h9);
        chk("k9_entry", {24'd0, entry},    32'h09);
        ack_once();
        chk("k9_ack_valid", {31'd0, key_valid}, 32'd0);
        tick(40);
        chk("k9_rises", rises, 1);
        pressed = '0;
        tick(80);

        // 3. Key 0x3 after release
        pressed = 16'h1 << 3;
        wait_valid(80);
        chk("k3_code",  {28'd0, key_code}, 32'h3);
        chk("k3_entry", {24'd0, entry},    32'h93);
        ack_once();
        tick(30);
        pressed = '0;
        tick(80);

        // 4. Key 0x5 bouncing every 10 clk, aligned to its column sample
        do tick(1); while (m_n % 16 != 5);
        rises = 0;
        pressed = 16'h1 << 5;
        for (int j = 0; j < 6; j++) begin
            tick(10);
            pressed = (j % 2 == 0) ? 16'h0 : (16'h1 << 5);
        end
        chk("bounce_rises", rises, 0);
        wait_valid(80);
        chk("k5_code",  {28'd0, key_code}, 32'h5);
        chk("k5_entry", {24'd0, entry},    32'h35);
        tick(20);
        chk("k5_rises", rises, 1);
        ack_once();
        pressed = '0;
        tick(80);

        // 5. Two keys together
        rises = 0;
        pressed = (16'h1 << 1) | (16'h1 << 2);
        tick(100);
        chk("multi_rises",   rises, 0);
        chk("multi_overrun", {31'd0, overrun}, 32'd0);
        pressed = '0;
        tick(80);

        // 6. Overrun without ack, then reset mid-scan
        pressed = 16'h1 << 4;
        wait_valid(80);
        tick(20);
        pressed = '0;
        tick(80);
        pressed = 16'h1 << 7;
        tick(100);
        chk("ovr_code",    {28'd0, key_code}, 32'h4);
        chk("ovr_flag",    {31'd0, overrun},  32'd1);
        chk("ovr_entry",   {24'd0, entry},    32'h54);
        ack_once();
        chk("ovr_ack_valid", {31'd0, key_valid}, 32'd0);
        chk("ovr_ack_flag",  {31'd0, overrun},   32'd0);
        pressed = '0;
        tick(80);
        pressed = 16'h1 << 4;
        wait_valid(80);
        tick(7);
        rst = 1'b1;
        tick(1);
        chk("rst_col",   {28'd0, col_out},   32'b1110);
        chk("rst_valid", {31'd0, key_valid}, 32'd0);
        chk("rst_code",  {28'd0, key_code},  32'd0);
        chk("rst_ovr",   {31'd0, overrun},   32'd0);
        chk("rst_entry", {24'd0, entry},     32'h00);
        rst = 1'b0;
        pressed = '0;
        tick(40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual timeout, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
